// File: rtl/gd_pkg.sv
// rtl/gd_pkg.sv - shared states, status codes and Q24.8 helpers for the gradient iteration controller
package gd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_UPDATE,
        S_FINISH
    } gd_state_e;

    localparam logic [1:0] ST_CONV  = 2'b00;
    localparam logic [1:0] ST_MAXIT = 2'b01;
    localparam logic [1:0] ST_OVF   = 2'b10;
    localparam logic [1:0] ST_TMO   = 2'b11;

    localparam int          Q_FRAC  = 8;
    localparam logic [31:0] Q24_MAX = 32'h7FFFFFFF;
    localparam logic [31:0] Q24_MIN = 32'h80000000;

    // Magnitude of a Q24.8 value; the most negative code has no positive twin.
    function automatic logic [31:0] abs_q24(input logic [31:0] v);
        if (v == Q24_MIN) begin
            return Q24_MAX;
        end else if (v[31]) begin
            return 32'(-v);
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/sat_sub_q24_8.sv
// rtl/sat_sub_q24_8.sv - Q24.8 subtract at 33 bits with out-of-range flag and clamped result
module sat_sub_q24_8
    import gd_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] res_o,
    output logic        ovf_o
);

    logic [32:0] wide;

    always_comb begin
        wide  = {a_i[31], a_i} - {b_i[31], b_i};
        ovf_o = wide[32] != wide[31];
        if (ovf_o) begin
            res_o = wide[32] ? Q24_MIN : Q24_MAX;
        end else begin
            res_o = wide[31:0];
        end
    end

endmodule

// File: rtl/gd_iter_ctrl.sv
// rtl/gd_iter_ctrl.sv - gradient-step iteration controller: launch, wait, update x, stop on convergence/limit/overflow/timeout
module gd_iter_ctrl
    import gd_pkg::*;
#(
    parameter int MAX_ITER = 64,
    parameter int TIMEOUT  = 256,
    parameter int ITER_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       x_init,
    input  logic [31:0]       tol,
    output logic              busy,
    output logic              done,
    output logic [31:0]       x_out,
    output logic [63:0]       value_out,
    output logic [ITER_W-1:0] iter_count,
    output logic [1:0]        status,
    output logic              step_start,
    output logic [31:0]       step_x,
    input  logic              step_done,
    input  logic [31:0]       step_x_diff,
    input  logic [63:0]       step_value,
    input  logic              step_overflow
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    gd_state_e         state_q, state_d;
    logic [31:0]       x_reg_q, x_reg_d;
    logic [31:0]       tol_q, tol_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [31:0]       xdiff_q, xdiff_d;
    logic [63:0]       val_q, val_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       x_out_q, x_out_d;
    logic [63:0]       value_out_q, value_out_d;
    logic [1:0]        status_q, status_d;

    logic [31:0]       sub_res;
    logic              sub_ovf;

    sat_sub_q24_8 u_sub (
        .a_i   (x_reg_q),
        .b_i   (xdiff_q),
        .res_o (sub_res),
        .ovf_o (sub_ovf)
    );

    always_comb begin
        state_d     = state_q;
        x_reg_d     = x_reg_q;
        tol_d       = tol_q;
        iter_d      = iter_q;
        wd_d        = wd_q;
        xdiff_d     = xdiff_q;
        val_d       = val_q;
        ovf_d       = ovf_q;
        x_out_d     = x_out_q;
        value_out_d = value_out_q;
        status_d    = status_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_reg_d  = x_init;
                    tol_d    = tol;
                    iter_d   = '0;
                    wd_d     = '0;
                    status_d = ST_CONV;
                    state_d  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the last allowed cycle still counts as a result.
                if (step_done) begin
                    xdiff_d = step_x_diff;
                    val_d   = step_value;
                    ovf_d   = step_overflow;
                    state_d = S_UPDATE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    status_d = ST_TMO;
                    state_d  = S_FINISH;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_UPDATE: begin
                iter_d  = iter_q + 1'b1;
                state_d = S_FINISH;
                if (ovf_q || sub_ovf) begin
                    status_d = ST_OVF;
                end else begin
                    x_reg_d = sub_res;
                    if (abs_q24(xdiff_q) <= tol_q) begin
                        status_d = ST_CONV;
                    end else if (iter_d == ITER_W'(MAX_ITER)) begin
                        status_d = ST_MAXIT;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_FINISH: begin
                x_out_d     = x_reg_q;
                value_out_d = val_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_reg_q     <= '0;
            tol_q       <= '0;
            iter_q      <= '0;
            wd_q        <= '0;
            xdiff_q     <= '0;
            val_q       <= '0;
            ovf_q       <= 1'b0;
            x_out_q     <= '0;
            value_out_q <= '0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            x_reg_q     <= x_reg_d;
            tol_q       <= tol_d;
            iter_q      <= iter_d;
            wd_q        <= wd_d;
            xdiff_q     <= xdiff_d;
            val_q       <= val_d;
            ovf_q       <= ovf_d;
            x_out_q     <= x_out_d;
            value_out_q <= value_out_d;
            status_q    <= status_d;
        end
    end

    assign busy       = state_q != S_IDLE;
    assign done       = state_q == S_FINISH;
    assign step_start = state_q == S_LAUNCH;
    assign step_x     = x_reg_q;
    assign x_out      = x_out_q;
    assign value_out  = value_out_q;
    assign iter_count = iter_q;
    assign status     = status_q;

endmodule

// File: tb/tb_gd_iter_ctrl.sv
// tb/tb_gd_iter_ctrl.sv - scoreboard bench for gd_iter_ctrl with a latency-3 halving step model
module tb_gd_iter_ctrl;

    typedef struct {
        logic [1:0]  st;
        logic [15:0] it;
        logic [31:0] x;
        logic [63:0] v;
        bit          chk_v;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s [2];
    logic [31:0] x_init_s, tol_s;

    logic        busy_w [2], done_w [2], step_start_w [2];
    logic [31:0] x_out_w [2], step_x_w [2];
    logic [63:0] value_out_w [2];
    logic [15:0] iter_w [2];
    logic [1:0]  status_w [2];

    logic        md_done [2] = '{1'b0, 1'b0};
    logic        md_ovf [2]  = '{1'b0, 1'b0};
    logic [31:0] md_diff [2] = '{32'h0, 32'h0};
    logic [63:0] md_val [2]  = '{64'h0, 64'h0};
    logic [31:0] xs [2];
    int          cnt [2];
    bit          pend [2];
    int          it [2];

    bit          m_hang, m_fixed;
    logic [31:0] m_fixed_diff;
    int          m_ovf_at;
    int          m_lat = 3;

    int cyc = 0;
    int c0;
    int n_pass = 0;
    int n_total = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gd_iter_ctrl #(.MAX_ITER(64), .TIMEOUT(16), .ITER_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_s[0]), .x_init(x_init_s), .tol(tol_s),
        .busy(busy_w[0]), .done(done_w[0]), .x_out(x_out_w[0]), .value_out(value_out_w[0]),
        .iter_count(iter_w[0]), .status(status_w[0]), .step_start(step_start_w[0]),
        .step_x(step_x_w[0]), .step_done(md_done[0]), .step_x_diff(md_diff[0]),
        .step_value(md_val[0]), .step_overflow(md_ovf[0])
    );

    gd_iter_ctrl #(.MAX_ITER(4), .TIMEOUT(16), .ITER_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_s[1]), .x_init(x_init_s), .tol(tol_s),
        .busy(busy_w[1]), .done(done_w[1]), .x_out(x_out_w[1]), .value_out(value_out_w[1]),
        .iter_count(iter_w[1]), .status(status_w[1]), .step_start(step_start_w[1]),
        .step_x(step_x_w[1]), .step_done(md_done[1]), .step_x_diff(md_diff[1]),
        .step_value(md_val[1]), .step_overflow(md_ovf[1])
    );

    // Step unit model: x_diff = x >>> 1, value = sext(x) + 2^32, done m_lat cycles after launch.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            md_done[k] = 1'b0;
            md_ovf[k]  = 1'b0;
            if (!busy_w[k]) it[k] = 0;
            if (step_start_w[k]) begin
                pend[k] = 1'b1;
                cnt[k]  = m_lat;
                xs[k]   = step_x_w[k];
                it[k]   = it[k] + 1;
            end else if (pend[k] && !m_hang) begin
                cnt[k] = cnt[k] - 1;
                if (cnt[k] == 0) begin
                    pend[k]    = 1'b0;
                    md_done[k] = 1'b1;
                    md_diff[k] = m_fixed ? m_fixed_diff : ($signed(xs[k]) >>> 1);
                    md_val[k]  = {{32{xs[k][31]}}, xs[k]} + 64'h1_0000_0000;
                    md_ovf[k]  = (it[k] == m_ovf_at);
                end
            end
        end
    end

    task automatic launch(input int sel, input logic [31:0] xi, input logic [31:0] tl);
        x_init_s     = xi;
        tol_s        = tl;
        start_s[sel] = 1'b1;
        c0           = cyc;
        @(negedge clk);
        start_s[sel] = 1'b0;
    endtask

    // Waits for done, then samples results in the following (IDLE) cycle.
    task automatic collect(input int sel, input int budget, output bit got, output logic [1:0] st,
                           output logic [15:0] itc, output logic [31:0] xo, output logic [63:0] vo,
                           output int when);
        got = 1'b0; st = 'x; itc = 'x; xo = 'x; vo = 'x; when = -1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (done_w[sel]) begin
                got  = 1'b1;
                when = cyc - c0;
            end
        end
        if (got) begin
            @(negedge clk);
            st = status_w[sel]; itc = iter_w[sel]; xo = x_out_w[sel]; vo = value_out_w[sel];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (busy_w[0] !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_w[0]); else n_pass++;
        n_total++; if (done_w[0] !== 1'b0) $display("FAIL rst_done: got %b want 0", done_w[0]); else n_pass++;
        n_total++; if (step_start_w[0] !== 1'b0) $display("FAIL rst_step_start: got %b want 0", step_start_w[0]); else n_pass++;
        n_total++; if (x_out_w[0] !== 32'h0) $display("FAIL rst_x_out: got %h want 0", x_out_w[0]); else n_pass++;
        n_total++; if (value_out_w[0] !== 64'h0) $display("FAIL rst_value_out: got %h want 0", value_out_w[0]); else n_pass++;
        n_total++; if ({iter_w[0], status_w[0]} !== 18'h0) $display("FAIL rst_iter_status: got %h/%b want 0/00", iter_w[0], status_w[0]); else n_pass++;
    endtask

    task automatic test_converge();
        bit got; logic [1:0] st; logic [15:0] itc; logic [31:0] xo; logic [63:0] vo; int when; exp_t e;
        exp_q.push_back('{2'b00, 16'd7, 32'h10, 64'h1_0000_0020, 1'b1, 36});
        launch(0, 32'h800, 32'h10);
        n_total++; if ({busy_w[0], step_start_w[0]} !== 2'b11) $display("FAIL conv_launch: got busy/start %b%b want 11", busy_w[0], step_start_w[0]); else n_pass++;
        n_total++; if (step_x_w[0] !== 32'h800) $display("FAIL conv_step_x: got %h want 00000800", step_x_w[0]); else n_pass++;
        collect(0, 200, got, st, itc, xo, vo, when);
        e = exp_q.pop_front();
        n_total++; if (!got) $display("FAIL conv_timeout: no done within budget"); else n_pass++;
        n_total++; if (st !== e.st) $display("FAIL conv_status: got %b want %b", st, e.st); else n_pass++;
        n_total++; if (itc !== e.it) $display("FAIL conv_iter: got %0d want %0d", itc, e.it); else n_pass++;
        n_total++; if (xo !== e.x) $display("FAIL conv_x_out: got %h want %h", xo, e.x); else n_pass++;
        n_total++; if (vo !== e.v) $display("FAIL conv_value: got %h want %h", vo, e.v); else n_pass++;
        n_total++; if (when !== e.cyc) $display("FAIL conv_done_cycle: got %0d want %0d", when, e.cyc); else n_pass++;
    endtask

    task automatic test_max_iter();
        bit got; logic [1:0] st; logic [15:0] itc; logic [31:0] xo; logic [63:0] vo; int when; exp_t e;
        exp_q.push_back('{2'b01, 16'd4, 32'h80, 64'h1_0000_0100, 1'b1, 21});
        launch(1, 32'h800, 32'h0);
        collect(1, 200, got, st, itc, xo, vo, when);
        e = exp_q.pop_front();
        n_total++; if (!got) $display("FAIL maxit_timeout: no done within budget"); else n_pass++;
        n_total++; if ({st, itc} !== {e.st, e.it}) $display("FAIL maxit_status_iter: got %b/%0d want %b/%0d", st, itc, e.st, e.it); else n_pass++;
        n_total++; if ({xo, vo} !== {e.x, e.v}) $display("FAIL maxit_x_value: got %h/%h want %h/%h", xo, vo, e.x, e.v); else n_pass++;
        n_total++; if (when !== e.cyc) $display("FAIL maxit_done_cycle: got %0d want %0d", when, e.cyc); else n_pass++;
    endtask

    task automatic test_overflow_flag();
        bit got; logic [1:0] st; logic [15:0] itc; logic [31:0] xo; logic [63:0] vo; int when; exp_t e;
        m_ovf_at = 2;
        exp_q.push_back('{2'b10, 16'd2, 32'h400, 64'h1_0000_0400, 1'b1, 11});
        launch(0, 32'h800, 32'h10);
        collect(0, 200, got, st, itc, xo, vo, when);
        m_ovf_at = 0;
        e = exp_q.pop_front();
        n_total++; if ({got, st, itc} !== {1'b1, e.st, e.it}) $display("FAIL ovf_flag_status_iter: got %b/%0d want %b/%0d", st, itc, e.st, e.it); else n_pass++;
        n_total++; if ({xo, vo} !== {e.x, e.v}) $display("FAIL ovf_flag_x_value: got %h/%h want %h/%h", xo, vo, e.x, e.v); else n_pass++;
        n_total++; if (when !== e.cyc) $display("FAIL ovf_flag_done_cycle: got %0d want %0d", when, e.cyc); else n_pass++;
    endtask

    task automatic test_overflow_range();
        bit got; logic [1:0] st; logic [15:0] itc; logic [31:0] xo; logic [63:0] vo; int when; exp_t e;
        m_fixed = 1'b1;
        m_fixed_diff = 32'h7FFFFF00;
        exp_q.push_back('{2'b10, 16'd1, 32'h80000100, 64'h0000_0000_8000_0100, 1'b1, 6});
        launch(0, 32'h80000100, 32'h10);
        collect(0, 200, got, st, itc, xo, vo, when);
        m_fixed = 1'b0;
        e = exp_q.pop_front();
        n_total++; if ({got, st, itc} !== {1'b1, e.st, e.it}) $display("FAIL ovf_range_status_iter: got %b/%0d want %b/%0d", st, itc, e.st, e.it); else n_pass++;
        n_total++; if ({xo, vo} !== {e.x, e.v}) $display("FAIL ovf_range_x_value: got %h/%h want %h/%h", xo, vo, e.x, e.v); else n_pass++;
        n_total++; if (when !== e.cyc) $display("FAIL ovf_range_done_cycle: got %0d want %0d", when, e.cyc); else n_pass++;
    endtask

    task automatic test_timeout();
        bit got; logic [1:0] st; logic [15:0] itc; logic [31:0] xo; logic [63:0] vo; int when; exp_t e;
        m_hang = 1'b1;
        exp_q.push_back('{2'b11, 16'd0, 32'h1234, 64'h0, 1'b0, 18});
        launch(0, 32'h1234, 32'h10);
        collect(0, 200, got, st, itc, xo, vo, when);
        m_hang = 1'b0;
        e = exp_q.pop_front();
        n_total++; if ({got, st, itc} !== {1'b1, e.st, e.it}) $display("FAIL tmo_status_iter: got %b/%0d want %b/%0d", st, itc, e.st, e.it); else n_pass++;
        n_total++; if (xo !== e.x) $display("FAIL tmo_x_out: got %h want %h", xo, e.x); else n_pass++;
        if (e.chk_v) begin
            n_total++; if (vo !== e.v) $display("FAIL tmo_value: got %h want %h", vo, e.v); else n_pass++;
        end
        n_total++; if (when !== e.cyc) $display("FAIL tmo_done_cycle: got %0d want %0d", when, e.cyc); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        bit got; logic [1:0] st; logic [15:0] itc; logic [31:0] xo; logic [63:0] vo; int when; exp_t e;
        bit stray;
        launch(0, 32'h800, 32'h10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++; if ({busy_w[0], done_w[0], step_start_w[0]} !== 3'b000) $display("FAIL mid_rst_ctrl: got %b%b%b want 000", busy_w[0], done_w[0], step_start_w[0]); else n_pass++;
        n_total++; if ({x_out_w[0], step_x_w[0]} !== 64'h0) $display("FAIL mid_rst_x: got %h/%h want 0/0", x_out_w[0], step_x_w[0]); else n_pass++;
        n_total++; if ({value_out_w[0], iter_w[0], status_w[0]} !== 82'h0) $display("FAIL mid_rst_outputs: got %h/%0d/%b want 0/0/00", value_out_w[0], iter_w[0], status_w[0]); else n_pass++;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy_w[0] || done_w[0] || iter_w[0] != 16'h0) stray = 1'b1;
        end
        n_total++; if (stray !== 1'b0) $display("FAIL stale_step_done: got activity 1 want 0"); else n_pass++;
        exp_q.push_back('{2'b00, 16'd7, 32'h10, 64'h1_0000_0020, 1'b1, 36});
        launch(0, 32'h800, 32'h10);
        repeat (4) @(negedge clk);
        x_init_s = 32'h5555;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        collect(0, 200, got, st, itc, xo, vo, when);
        e = exp_q.pop_front();
        n_total++; if ({got, st, itc} !== {1'b1, e.st, e.it}) $display("FAIL rerun_status_iter: got %b/%0d want %b/%0d", st, itc, e.st, e.it); else n_pass++;
        n_total++; if ({xo, vo} !== {e.x, e.v}) $display("FAIL rerun_x_value: got %h/%h want %h/%h", xo, vo, e.x, e.v); else n_pass++;
        n_total++; if (when !== e.cyc) $display("FAIL rerun_done_cycle: got %0d want %0d", when, e.cyc); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit got; logic [1:0] st; logic [15:0] itc; logic [31:0] xo; logic [63:0] vo; int when; exp_t e;
        exp_q.push_back('{2'b00, 16'd7, 32'h10, 64'h1_0000_0020, 1'b1, 36});
        exp_q.push_back('{2'b00, 16'd8, 32'h10, 64'h1_0000_0020, 1'b1, 41});
        launch(0, 32'h800, 32'h10);
        collect(0, 200, got, st, itc, xo, vo, when);
        e = exp_q.pop_front();
        n_total++; if ({got, st, itc, xo} !== {1'b1, e.st, e.it, e.x}) $display("FAIL b2b_first: got %b/%0d/%h want %b/%0d/%h", st, itc, xo, e.st, e.it, e.x); else n_pass++;
        launch(0, 32'h1000, 32'h10);
        n_total++; if (busy_w[0] !== 1'b1) $display("FAIL b2b_accept: got busy %b want 1", busy_w[0]); else n_pass++;
        collect(0, 200, got, st, itc, xo, vo, when);
        e = exp_q.pop_front();
        n_total++; if ({got, st, itc} !== {1'b1, e.st, e.it}) $display("FAIL b2b_second_status_iter: got %b/%0d want %b/%0d", st, itc, e.st, e.it); else n_pass++;
        n_total++; if ({xo, vo} !== {e.x, e.v}) $display("FAIL b2b_second_x_value: got %h/%h want %h/%h", xo, vo, e.x, e.v); else n_pass++;
        n_total++; if (when !== e.cyc) $display("FAIL b2b_second_done_cycle: got %0d want %0d", when, e.cyc); else n_pass++;
    endtask

    initial begin
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        x_init_s = 32'h0;
        tol_s = 32'h0;
        m_hang = 1'b0;
        m_fixed = 1'b0;
        m_fixed_diff = 32'h0;
        m_ovf_at = 0;
        c0 = 0;
        test_reset();
        test_converge();
        test_max_iter();
        test_overflow_flag();
        test_overflow_range();
        test_timeout();
        test_reset_midrun();
        test_back_to_back();
        n_total++; if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
